// File: rtl/image_pkg.sv
// Shared types and default sizing for the pixel stream writer.
package image_pkg;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      WRITE   = 2'd1,
      FULL    = 2'd2
   } state_e;

   localparam int DEF_BYTES_PER_PIXEL = 3;
   localparam int DEF_ADDR_W          = 18;
   localparam int DEF_NUM_PIXELS      = 66564;
   localparam int DEF_TIMEOUT_CYC     = 50000;

   // Counter width able to hold 0..limit-1, never narrower than one bit.
   function automatic int cnt_width(input int limit);
      return (limit > 1) ? $clog2(limit) : 1;
   endfunction

endpackage

// File: rtl/pixel_stream_writer_byte_assembler.sv
// Packs incoming bytes into one pixel word and flags the byte that completes it.
module byte_assembler
   import image_pkg::*;
#(
   parameter  int BYTES_PER_PIXEL = DEF_BYTES_PER_PIXEL,
   localparam int CNT_W           = cnt_width(BYTES_PER_PIXEL),
   localparam int WORD_W          = 8 * BYTES_PER_PIXEL
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              accept,
   input  logic              lsb_first,
   input  logic [7:0]        byte_in,
   output logic [CNT_W-1:0]  byte_cnt,
   output logic [WORD_W-1:0] word_next,
   output logic              word_done
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES_PER_PIXEL - 1);

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WORD_W-1:0] asm_q, asm_d;
   logic [CNT_W-1:0]  slot;

   // word_next already contains the current byte so the last byte can be
   // written straight out without waiting for the assembly register.
   always_comb begin
      slot      = lsb_first ? cnt_q : (LAST - cnt_q);
      word_next = asm_q;
      for (int i = 0; i < BYTES_PER_PIXEL; i++) begin
         if (accept && (slot == CNT_W'(i))) begin
            word_next[i*8 +: 8] = byte_in;
         end
      end
      word_done = accept && (cnt_q == LAST);
   end

   always_comb begin
      cnt_d = cnt_q;
      asm_d = asm_q;
      if (clear) begin
         cnt_d = '0;
         asm_d = '0;
      end else if (accept) begin
         asm_d = word_next;
         cnt_d = word_done ? '0 : (cnt_q + CNT_W'(1));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         asm_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         asm_q <= asm_d;
      end
   end

   assign byte_cnt = cnt_q;

endmodule

// File: rtl/pixel_stream_writer.sv
// Turns a byte stream into one memory write per pixel, with frame limit and stale-byte timeout.
//   state   | meaning
//   COLLECT | gathering bytes of the current pixel
//   WRITE   | en/we high for one clock, din/addr present the pixel
//   FULL    | frame complete, further bytes flag overflow
module pixel_stream_writer
   import image_pkg::*;
#(
   parameter int BYTES_PER_PIXEL = DEF_BYTES_PER_PIXEL,
   parameter int ADDR_W          = DEF_ADDR_W,
   parameter int NUM_PIXELS      = DEF_NUM_PIXELS,
   parameter int TIMEOUT_CYC     = DEF_TIMEOUT_CYC
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [7:0]                   byte_received,
   input  logic                         rx_data_ready,
   input  logic                         frame_start,
   input  logic                         lsb_first,
   output logic                         en,
   output logic                         we,
   output logic [ADDR_W-1:0]            addr,
   output logic [8*BYTES_PER_PIXEL-1:0] din,
   output logic                         frame_done,
   output logic                         overflow,
   output logic                         timeout_drop
);

   localparam int WORD_W = 8 * BYTES_PER_PIXEL;
   localparam int CNT_W  = cnt_width(BYTES_PER_PIXEL);
   localparam int PIX_W  = cnt_width(NUM_PIXELS);
   localparam int IDLE_W = cnt_width(TIMEOUT_CYC + 1);
   localparam bit TO_EN  = (TIMEOUT_CYC > 0);

   localparam logic [PIX_W-1:0]  LAST_PIX = PIX_W'(NUM_PIXELS - 1);
   localparam logic [IDLE_W-1:0] TO_LIM   = IDLE_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

   state_e              state_q, state_d;
   logic [PIX_W-1:0]    pix_q, pix_d;
   logic [IDLE_W-1:0]   idle_q, idle_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [WORD_W-1:0]   din_q, din_d;
   logic                wr_q, wr_d;
   logic                frame_done_q, frame_done_d;
   logic                overflow_q, overflow_d;
   logic                timeout_drop_q, timeout_drop_d;

   logic                rx_ok, last_pix, accept, ovf_hit;
   logic                idle_run, timeout_hit, asm_clear;
   logic [PIX_W-1:0]    pix_inc;
   logic [CNT_W-1:0]    byte_cnt;
   logic [WORD_W-1:0]   word_next;
   logic                word_done;

   // A byte arriving while the final pixel is being written has no slot left
   // in the frame, so it is treated like a byte arriving in FULL.
   always_comb begin
      rx_ok       = rx_data_ready && !frame_start;
      last_pix    = (pix_q == LAST_PIX);
      pix_inc     = pix_q + PIX_W'(1);
      accept      = rx_ok && ((state_q == COLLECT) || ((state_q == WRITE) && !last_pix));
      ovf_hit     = rx_ok && ((state_q == FULL) || ((state_q == WRITE) && last_pix));
      idle_run    = TO_EN && (state_q == COLLECT) && (byte_cnt != '0)
                    && !rx_data_ready && !frame_start;
      timeout_hit = idle_run && (idle_q == TO_LIM);
   end

   assign asm_clear = frame_start || timeout_hit;

   byte_assembler #(
      .BYTES_PER_PIXEL (BYTES_PER_PIXEL)
   ) u_asm (
      .clk       (clk),
      .rst       (rst),
      .clear     (asm_clear),
      .accept    (accept),
      .lsb_first (lsb_first),
      .byte_in   (byte_received),
      .byte_cnt  (byte_cnt),
      .word_next (word_next),
      .word_done (word_done)
   );

   always_comb begin
      state_d        = state_q;
      pix_d          = pix_q;
      addr_d         = addr_q;
      din_d          = din_q;
      wr_d           = 1'b0;
      frame_done_d   = 1'b0;
      overflow_d     = overflow_q || ovf_hit;
      timeout_drop_d = timeout_hit;
      idle_d         = (idle_run && !timeout_hit) ? (idle_q + IDLE_W'(1)) : '0;

      unique case (state_q)
         COLLECT: begin
            if (word_done) begin
               state_d = WRITE;
               wr_d    = 1'b1;
               addr_d  = ADDR_W'(pix_q);
               din_d   = word_next;
            end
         end
         WRITE: begin
            if (last_pix) begin
               state_d      = FULL;
               frame_done_d = 1'b1;
            end else begin
               pix_d = pix_inc;
               // Single-byte pixels can complete again while still in WRITE.
               if (word_done) begin
                  wr_d   = 1'b1;
                  addr_d = ADDR_W'(pix_inc);
                  din_d  = word_next;
               end else begin
                  state_d = COLLECT;
               end
            end
         end
         FULL: begin
            state_d = FULL;
         end
         default: begin
            state_d = COLLECT;
         end
      endcase

      if (frame_start) begin
         state_d        = COLLECT;
         pix_d          = '0;
         idle_d         = '0;
         wr_d           = 1'b0;
         frame_done_d   = 1'b0;
         overflow_d     = 1'b0;
         timeout_drop_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= COLLECT;
         pix_q          <= '0;
         idle_q         <= '0;
         addr_q         <= '0;
         din_q          <= '0;
         wr_q           <= 1'b0;
         frame_done_q   <= 1'b0;
         overflow_q     <= 1'b0;
         timeout_drop_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         pix_q          <= pix_d;
         idle_q         <= idle_d;
         addr_q         <= addr_d;
         din_q          <= din_d;
         wr_q           <= wr_d;
         frame_done_q   <= frame_done_d;
         overflow_q     <= overflow_d;
         timeout_drop_q <= timeout_drop_d;
      end
   end

   assign en           = wr_q;
   assign we           = wr_q;
   assign addr         = addr_q;
   assign din          = din_q;
   assign frame_done   = frame_done_q;
   assign overflow     = overflow_q;
   assign timeout_drop = timeout_drop_q;

endmodule

// File: tb/tb_pixel_stream_writer.sv
// Directed bench: a 3-byte/4-pixel/timeout-10 writer and a 1-byte/4-pixel writer.
module tb_pixel_stream_writer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;

   logic [7:0]  byte_a;
   logic        rx_a, fs_a, lsb_a;
   logic        en_a, we_a, fd_a, ovf_a, to_a;
   logic [17:0] addr_a;
   logic [23:0] din_a;

   logic [7:0]  byte_b;
   logic        rx_b, fs_b, lsb_b;
   logic        en_b, we_b, fd_b, ovf_b, to_b;
   logic [3:0]  addr_b;
   logic [7:0]  din_b;

   pixel_stream_writer #(
      .BYTES_PER_PIXEL (3),
      .ADDR_W          (18),
      .NUM_PIXELS      (4),
      .TIMEOUT_CYC     (10)
   ) dut_a (
      .clk           (clk),
      .rst           (rst),
      .byte_received (byte_a),
      .rx_data_ready (rx_a),
      .frame_start   (fs_a),
      .lsb_first     (lsb_a),
      .en            (en_a),
      .we            (we_a),
      .addr          (addr_a),
      .din           (din_a),
      .frame_done    (fd_a),
      .overflow      (ovf_a),
      .timeout_drop  (to_a)
   );

   pixel_stream_writer #(
      .BYTES_PER_PIXEL (1),
      .ADDR_W          (4),
      .NUM_PIXELS      (4),
      .TIMEOUT_CYC     (0)
   ) dut_b (
      .clk           (clk),
      .rst           (rst),
      .byte_received (byte_b),
      .rx_data_ready (rx_b),
      .frame_start   (fs_b),
      .lsb_first     (lsb_b),
      .en            (en_b),
      .we            (we_b),
      .addr          (addr_b),
      .din           (din_b),
      .frame_done    (fd_b),
      .overflow      (ovf_b),
      .timeout_drop  (to_b)
   );

   // Event counters, written only here and sampled mid-cycle.
   int wr_a_cnt = 0, fd_a_cnt = 0, to_a_cnt = 0, wr_b_cnt = 0;
   always @(negedge clk) begin
      if (en_a && we_a) wr_a_cnt++;
      if (fd_a)         fd_a_cnt++;
      if (to_a)         to_a_cnt++;
      if (en_b && we_b) wr_b_cnt++;
   end

   int nchk = 0;
   int nerr = 0;
   int w0, f0, t0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_a(input logic [7:0] b);
      byte_a = b;
      rx_a   = 1'b1;
      step();
      rx_a   = 1'b0;
   endtask

   task automatic send_b(input logic [7:0] b);
      byte_b = b;
      rx_b   = 1'b1;
      step();
      rx_b   = 1'b0;
   endtask

   task automatic restart_a();
      fs_a = 1'b1;
      step();
      fs_a = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst   = 1'b1;
      byte_a = 8'h00; rx_a = 1'b0; fs_a = 1'b0; lsb_a = 1'b0;
      byte_b = 8'h00; rx_b = 1'b0; fs_b = 1'b0; lsb_b = 1'b0;
      repeat (2) step();

      chk("rst_flags_a", {27'd0, en_a, we_a, fd_a, ovf_a, to_a}, 32'd0);
      chk("rst_addr_a", addr_a, 32'd0);
      chk("rst_din_a", din_a, 32'd0);
      rst = 1'b0;
      step();

      // One-byte pixels: every byte writes on the following clock.
      for (int i = 0; i < 4; i++) begin
         send_b(8'h31 + 8'(i));
         chk("b1_en", en_b, 32'd1);
         chk("b1_addr", addr_b, i);
         chk("b1_din", din_b, 32'h31 + i);
      end
      step();
      chk("b1_frame_done", fd_b, 32'd1);
      chk("b1_flags", {29'd0, ovf_b, to_b, we_b}, 32'd0);
      chk("b1_wr_count", wr_b_cnt, 32'd4);

      // MS-first assembly, write one clock after the third byte.
      w0 = wr_a_cnt;
      send_a(8'h01); send_a(8'h02); send_a(8'h03);
      chk("msb_en_we", {en_a, we_a}, 32'd3);
      chk("msb_addr", addr_a, 32'd0);
      chk("msb_din", din_a, 32'h010203);
      step();
      chk("msb_en_low", {en_a, we_a}, 32'd0);
      chk("msb_din_hold", din_a, 32'h010203);
      chk("msb_wr_count", wr_a_cnt - w0, 32'd1);

      // LS-first assembly.
      restart_a();
      lsb_a = 1'b1;
      send_a(8'h01); send_a(8'h02); send_a(8'h03);
      chk("lsb_din", din_a, 32'h030201);
      chk("lsb_addr", addr_a, 32'd0);
      step();
      lsb_a = 1'b0;

      // Full frame of 4 pixels from back-to-back bytes, then one extra byte.
      restart_a();
      w0 = wr_a_cnt;
      f0 = fd_a_cnt;
      for (int i = 0; i < 12; i++) send_a(8'h10 + 8'(i));
      chk("full_last_en", en_a, 32'd1);
      chk("full_last_addr", addr_a, 32'd3);
      chk("full_last_din", din_a, 32'h191A1B);
      step();
      chk("full_frame_done", fd_a, 32'd1);
      chk("full_ovf_before", ovf_a, 32'd0);
      send_a(8'hEE);
      chk("full_ovf_set", ovf_a, 32'd1);
      repeat (3) step();
      chk("full_ovf_sticky", ovf_a, 32'd1);
      chk("full_wr_count", wr_a_cnt - w0, 32'd4);
      chk("full_fd_count", fd_a_cnt - f0, 32'd1);
      chk("full_din_hold", din_a, 32'h191A1B);

      // frame_start beats a simultaneous strobe.
      restart_a();
      for (int i = 0; i < 6; i++) send_a(8'h20 + 8'(i));
      step();
      w0 = wr_a_cnt;
      byte_a = 8'h55; rx_a = 1'b1; fs_a = 1'b1;
      step();
      rx_a = 1'b0; fs_a = 1'b0;
      chk("fs_ovf_clear", ovf_a, 32'd0);
      send_a(8'hA1); send_a(8'hA2); send_a(8'hA3);
      chk("fs_addr", addr_a, 32'd0);
      chk("fs_din", din_a, 32'hA1A2A3);
      step();
      chk("fs_wr_count", wr_a_cnt - w0, 32'd1);

      // Partial pixel dropped after 10 idle clocks.
      restart_a();
      w0 = wr_a_cnt;
      t0 = to_a_cnt;
      send_a(8'h11); send_a(8'h22);
      repeat (9) step();
      chk("to_not_yet", to_a_cnt - t0, 32'd0);
      repeat (3) step();
      chk("to_one_pulse", to_a_cnt - t0, 32'd1);
      chk("to_no_write", wr_a_cnt - w0, 32'd0);
      send_a(8'hAA); send_a(8'hBB); send_a(8'hCC);
      chk("to_en", en_a, 32'd1);
      chk("to_addr", addr_a, 32'd0);
      chk("to_din", din_a, 32'hAABBCC);
      step();

      // Asynchronous reset between bytes of the second pixel.
      restart_a();
      send_a(8'h01); send_a(8'h02); send_a(8'h03);
      step();
      send_a(8'h44);
      #2 rst = 1'b1;
      #1;
      chk("arst_flags", {27'd0, en_a, we_a, fd_a, ovf_a, to_a}, 32'd0);
      chk("arst_addr_din", {addr_a, din_a} == 42'd0, 32'd1);
      step();
      step();
      rst = 1'b0;
      w0 = wr_a_cnt;
      send_a(8'hC1); send_a(8'hC2); send_a(8'hC3);
      chk("arst_addr", addr_a, 32'd0);
      chk("arst_din", din_a, 32'hC1C2C3);
      step();
      chk("arst_wr_count", wr_a_cnt - w0, 32'd1);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/pixel_stream_writer.md
PIXEL_STREAM_WRITER -- requirements
Module: pixel_stream_writer

Interface
REQ-001 Parameter BYTES_PER_PIXEL, default 3: bytes per pixel word, legal range 1..4.
REQ-002 Parameter ADDR_W, default 18: memory address width.
REQ-003 Parameter NUM_PIXELS, default 66564: pixel writes per frame, at most 2**ADDR_W.
REQ-004 Parameter TIMEOUT_CYC, default 50000: idle clocks after which a partial pixel is discarded; 0 disables the timeout.
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 byte_received  in  8  received byte; valid only while rx_data_ready=1.
REQ-008 rx_data_ready  in  1  one-clock strobe; each high clock is one byte.
REQ-009 frame_start  in  1  synchronous restart of frame.
REQ-010 lsb_first  in  1  0: first byte lands in the MS byte of din; 1: first byte lands in the LS byte.
REQ-011 en  out  1  memory enable.
REQ-012 we  out  1  memory write enable.
REQ-013 addr  out  ADDR_W  pixel address.
REQ-014 din  out  8*BYTES_PER_PIXEL  pixel data.
REQ-015 frame_done  out  1  one-clock pulse when the frame completes.
REQ-016 overflow  out  1  sticky flag for a byte arriving while FULL.
REQ-017 timeout_drop  out  1  one-clock pulse when a partial pixel is discarded.

Function
REQ-018 The FSM SHALL have exactly three states: COLLECT, WRITE and FULL.
REQ-019 In COLLECT, each rx_data_ready SHALL store the byte into the assembly register at the position given by byte_cnt and lsb_first, then increment byte_cnt.
REQ-020 The last byte (byte_cnt = BYTES_PER_PIXEL-1) SHALL clear byte_cnt and move the FSM to WRITE.
REQ-021 In WRITE, en=we=1 for exactly one clock, with din = assembled word and addr = current pixel index; this is the clock after the last byte is sampled.
REQ-022 Leaving WRITE, the pixel index SHALL increment; if the written index was NUM_PIXELS-1, the FSM SHALL go to FULL, otherwise to COLLECT.
REQ-023 A byte strobed during WRITE SHALL be accepted as byte 0 of the next pixel and SHALL NOT be lost.
REQ-024 frame_done SHALL pulse on the first clock in FULL.
REQ-025 In FULL, bytes SHALL be ignored, en=we=0, and overflow SHALL be set until reset or frame_start.
REQ-026 Outside WRITE, en=we=0, while din and addr hold their last values.
REQ-027 frame_start SHALL force COLLECT and clear the pixel index, byte_cnt, overflow and timeout counter; it takes priority over a simultaneous rx_data_ready, whose byte is discarded.
REQ-028 Timeout: in COLLECT with byte_cnt≠0, the idle counter counts clocks without rx_data_ready; on reaching TIMEOUT_CYC, byte_cnt clears, the pixel index is unchanged and timeout_drop pulses.
REQ-029 The idle counter SHALL clear on any accepted byte and whenever byte_cnt=0.
REQ-030 When BYTES_PER_PIXEL=1, every byte SHALL produce a write on the following clock.
REQ-031 All counters SHALL be sized by $clog2 of their limits; no wrap occurs before FULL.

Reset
REQ-032 rst SHALL asynchronously set: state=COLLECT; pixel index, byte_cnt, idle counter, addr and din = 0; en, we, frame_done, overflow and timeout_drop = 0.
REQ-033 Reset mid-pixel or mid-frame SHALL discard all partial data, with no write issued.

Structure
REQ-034 Package image_pkg SHALL hold the state enum (COLLECT, WRITE, FULL) and the default parameter constants (3, 18, 66564, 50000).
REQ-035 One sub-module, byte_assembler, SHALL hold the assembly register and byte_cnt and flag the completed word; pixel_stream_writer holds the FSM, address counter and timeout logic.

Verification
REQ-036 Bytes 01,02,03 with lsb_first=0 -> one write, din=24'h010203, addr=0, en=we=1 for exactly one clock, one clock after the third strobe.
REQ-037 Same bytes with lsb_first=1 -> din=24'h030201.
REQ-038 NUM_PIXELS=4 with 13 bytes -> writes to addr 0..3, frame_done one pulse, 13th byte sets overflow, no fifth write.
REQ-039 TIMEOUT_CYC=10: two bytes, idle 10 clocks, then AA,BB,CC -> timeout_drop one pulse, write din=24'hAABBCC at addr 0.
REQ-040 frame_start coincident with a strobe after 2 pixels -> byte discarded, overflow=0, next pixel written at addr 0.
REQ-041 rst asserted between bytes 1 and 2 -> all outputs 0 immediately (asynchronous); 3 new bytes produce a write at addr 0.
